bus_mem_slave: RTL and testbench
================================

BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

Interface
- REQ-001: The module SHALL have parameter ADDR_W, default 6, meaning address width.
- REQ-002: The module SHALL have parameter DATA_W, default 8, meaning data width.
- REQ-003: The module SHALL have port clk, input, 1, the system clock (25 MHz nominal, 40 ns period).
- REQ-004: The module SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-005: The module SHALL have port en, input, 1, access request.
- REQ-006: The module SHALL have port wr, input, 1, access direction (1 = write, 0 = read); ignored when en=0.
- REQ-007: The module SHALL have port addr, input, ADDR_W, word address.
- REQ-008: The module SHALL have port din, input, DATA_W, write data.
- REQ-009: The module SHALL have port ready, output, 1, slave can accept a request this cycle.
- REQ-010: The module SHALL have port wack, output, 1, one-cycle write-acknowledge pulse.
- REQ-011: The module SHALL have port dout, output, DATA_W, read data, meaningful only while rvalid=1.
- REQ-012: The module SHALL have port rvalid, output, 1, one-cycle read-data-valid pulse.
- REQ-013: The module SHALL have port wr_cnt, output, 8, saturating count of accepted writes.
- REQ-014: The module SHALL have port rd_cnt, output, 8, saturating count of accepted reads.

Function
- REQ-015: Storage SHALL be 2**ADDR_W words of DATA_W bits (64 x 8 at defaults).
- REQ-016: The FSM SHALL have exactly the states IDLE, READ and RESP.
- REQ-017: ready SHALL equal 1 iff state is IDLE (combinational from state).
- REQ-018: A request SHALL be accepted at a posedge where en=1 and state is IDLE; requests in READ or RESP SHALL be ignored, not queued.
- REQ-019: Accepted write: mem[addr] SHALL take din at the accepting edge, state SHALL remain IDLE, and wack SHALL be 1 for the following cycle.
- REQ-020: Back-to-back writes on consecutive cycles SHALL each be accepted, with wack staying high continuously.
- REQ-021: Accepted read: addr SHALL be registered and state SHALL go IDLE->READ.
- REQ-022: From READ the FSM SHALL go to RESP on the next edge, with dout loaded from mem[registered addr].
- REQ-023: In RESP, rvalid SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
- REQ-024: Read latency from the accepting edge to rvalid high SHALL be 2 cycles; minimum read-to-next-request spacing SHALL be 3 cycles.
- REQ-025: dout SHALL hold its last value outside RESP; rvalid SHALL be 0 outside RESP.
- REQ-026: A write accepted on the cycle directly before a read to the same address SHALL have that read return the newly written data.
- REQ-027: wr_cnt SHALL increment per accepted write and rd_cnt per accepted read; both SHALL saturate at 255 with no wrap.
- REQ-028: en=0 SHALL leave memory, counters and state unchanged (except the normal READ->RESP->IDLE progression).
- REQ-029: X on wr while en=0 SHALL have no effect.

Reset
- REQ-030: rst=1 SHALL asynchronously force state=IDLE, wack=0, rvalid=0, dout=0, wr_cnt=0, rd_cnt=0, and all memory words to 0.
- REQ-031: A reset asserted during READ or RESP SHALL abort the read; no rvalid pulse SHALL follow deassertion.
- REQ-032: The first request SHALL be accepted at the first posedge after rst deasserts.

Structure
- REQ-033: Package bus_mem_pkg SHALL hold the state typedef (IDLE, READ, RESP) and the ADDR_W/DATA_W default constants.
- REQ-034: The two counters SHALL be instances of one sub-module, sat_cnt (8-bit, inc input, saturate at max, async active-high reset).
- REQ-035: All remaining logic SHALL reside in bus_mem_slave.

Verification
- REQ-036: Reset then read addr 0x15 -> rvalid at edge+2, dout=0x00, rd_cnt=1.
- REQ-037: Write 0xA5 to 0x3F, then read 0x3F the next cycle -> wack=1 one cycle after the write; rvalid two cycles after the read accept with dout=0xA5.
- REQ-038: Pattern wr=en=1 for 2 cycles (0x01<-0x11, 0x02<-0x22), then wr=0/en=1 for 1 cycle at 0x02, then en=0 -> wr_cnt=2, rd_cnt=1, dout=0x22, wack high 2 cycles.
- REQ-039: Hold en=1 with wr=0 continuously for 9 cycles -> exactly 3 reads accepted, ready pattern 1,0,0 repeating, rd_cnt=3.
- REQ-040: Assert rst mid-READ -> state IDLE immediately, no rvalid afterward, memory reads back 0.
- REQ-041: Perform 300 writes -> wr_cnt=255 and stays 255.

Source files
------------

// File: rtl/bus_mem_pkg.sv
// Shared types and default sizes for the bus memory slave.
// Holds the FSM state encoding and the default address, data and counter widths.
package bus_mem_pkg;

  localparam int BUS_ADDR_W = 6;
  localparam int BUS_DATA_W = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: steps by one per inc and sticks at all-ones.
// Used by the bus memory slave for its write and read statistics.
module sat_cnt
  import bus_mem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_mem_slave.sv
// Single-port memory slave: writes complete in one cycle and are acknowledged with wack;
// reads take IDLE->READ->RESP and return data with a one-cycle rvalid pulse.
module bus_mem_slave
  import bus_mem_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              wack,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              wr_acc;
  logic              rd_acc;

  assign ready  = (state == IDLE);
  // en gates wr first so an undriven wr on idle cycles cannot leak into acceptance
  assign wr_acc = en & ready & wr;
  assign rd_acc = en & ready & ~wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_acc) begin
      mem[addr] <= din;
    end
  end

  // Reads never overlap a write, so the array is stable while READ fetches from addr_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      wack   <= 1'b0;
      rvalid <= 1'b0;
      dout   <= '0;
    end else begin
      wack   <= 1'b0;
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_acc) begin
            wack <= 1'b1;
          end else if (rd_acc) begin
            addr_q <= addr;
            state  <= READ;
          end
        end
        READ: begin
          dout   <= mem[addr_q];
          rvalid <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sat_cnt #(.W(CNT_W)) u_wr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .cnt (wr_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .cnt (rd_cnt)
  );

endmodule

// File: tb/tb_bus_mem_slave.sv
// Randomised self-checking bench for bus_mem_slave against a cycle-count reference model.
// The model tracks busy cycles remaining after a read, a plain memory array and saturating totals.
module tb_bus_mem_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       wr = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] din = '0;
  logic       ready, wack, rvalid;
  logic [7:0] dout, wr_cnt, rd_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_mem [64];
  int         busy;
  logic [5:0] m_raddr;
  logic       m_wack, m_rvalid;
  logic [7:0] m_dout;
  int         m_wcnt, m_rcnt;

  always #20 clk = ~clk;

  bus_mem_slave #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .wr     (wr),
    .addr   (addr),
    .din    (din),
    .ready  (ready),
    .wack   (wack),
    .dout   (dout),
    .rvalid (rvalid),
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt)
  );

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    busy = 0; m_raddr = '0; m_wack = 1'b0; m_rvalid = 1'b0;
    m_dout = 8'h00; m_wcnt = 0; m_rcnt = 0;
  endfunction

  // A read occupies the slave for three cycles and presents data in the second one after acceptance.
  function automatic void model_edge(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
    bit acc;
    acc = (e === 1'b1) && (busy == 0);
    m_wack = 1'b0;
    m_rvalid = 1'b0;
    if (busy == 2) begin
      m_rvalid = 1'b1;
      m_dout = m_mem[m_raddr];
    end
    if (busy > 0) busy--;
    if (acc && (w === 1'b1)) begin
      m_mem[a] = d;
      m_wack = 1'b1;
      if (m_wcnt < 255) m_wcnt++;
    end else if (acc) begin
      m_raddr = a;
      busy = 2;
      if (m_rcnt < 255) m_rcnt++;
    end
  endfunction

  task automatic drive(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
    en = e; wr = w; addr = a; din = d;
    @(posedge clk);
    model_edge(e, w, a, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; wr = 1'b0;
    model_reset();
    #5;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (wack !== 1'b0) begin errors++; $display("FAIL reset_wack got %b want 0", wack); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    checks++; if (wr_cnt !== 8'd0 || rd_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnts got %0d/%0d want 0/0", wr_cnt, rd_cnt); end
    // first request straight after reset release: read 0x15
    drive(1'b1, 1'b0, 6'h15, 8'($urandom));
    checks++; if (ready !== 1'b0 || rd_cnt !== 8'd1) begin errors++; $display("FAIL first_read_accept got ready=%b rd_cnt=%0d want 0/1", ready, rd_cnt); end
    drive(1'b0, 1'b0, 6'($urandom), 8'($urandom));
    checks++; if (rvalid !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL first_read_data got rvalid=%b dout=%h want 1/00", rvalid, dout); end
    drive(1'b0, 1'b0, 6'($urandom), 8'($urandom));
    checks++; if (rvalid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL first_read_end got rvalid=%b ready=%b want 0/1", rvalid, ready); end
  endtask

  task automatic test_write_then_read();
    drive(1'b1, 1'b1, 6'h3F, 8'hA5);
    checks++; if (wack !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL wr_ack got wack=%b ready=%b want 1/1", wack, ready); end
    drive(1'b1, 1'b0, 6'h3F, 8'($urandom));
    checks++; if (wack !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL wr_rd_gap got wack=%b rvalid=%b want 0/0", wack, rvalid); end
    drive(1'b1, 1'b1, 6'h3F, 8'h00);  // ignored: slave busy
    checks++; if (rvalid !== 1'b1 || dout !== 8'hA5) begin errors++; $display("FAIL wr_rd_data got rvalid=%b dout=%h want 1/a5", rvalid, dout); end
    checks++; if (wack !== 1'b0 || wr_cnt !== 8'd1) begin errors++; $display("FAIL busy_ignored got wack=%b wr_cnt=%0d want 0/1", wack, wr_cnt); end
    drive(1'b0, 1'bx, 6'($urandom), 8'($urandom));
    checks++; if (dout !== 8'hA5 || rvalid !== 1'b0) begin errors++; $display("FAIL dout_hold got dout=%h rvalid=%b want a5/0", dout, rvalid); end
  endtask

  task automatic test_back_to_back();
    int wack_hi;
    do_reset();
    wack_hi = 0;
    drive(1'b1, 1'b1, 6'h01, 8'h11); wack_hi += int'(wack);
    drive(1'b1, 1'b1, 6'h02, 8'h22); wack_hi += int'(wack);
    checks++; if (wack !== 1'b1) begin errors++; $display("FAIL b2b_wack_cont got %b want 1", wack); end
    drive(1'b1, 1'b0, 6'h02, 8'h00); wack_hi += int'(wack);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'bx, 6'($urandom), 8'($urandom)); wack_hi += int'(wack);
    end
    checks++; if (wr_cnt !== 8'd2 || rd_cnt !== 8'd1) begin errors++; $display("FAIL b2b_cnts got %0d/%0d want 2/1", wr_cnt, rd_cnt); end
    checks++; if (dout !== 8'h22) begin errors++; $display("FAIL b2b_dout got %h want 22", dout); end
    checks++; if (wack_hi !== 2) begin errors++; $display("FAIL b2b_wack_cycles got %0d want 2", wack_hi); end
  endtask

  task automatic test_continuous_read();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ready !== ((i % 3) == 0)) begin errors++; $display("FAIL cont_ready cycle %0d got %b want %b", i, ready, (i % 3) == 0); end
      drive(1'b1, 1'b0, 6'($urandom), 8'($urandom));
    end
    checks++; if (rd_cnt !== 8'd3) begin errors++; $display("FAIL cont_rd_cnt got %0d want 3", rd_cnt); end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    drive(1'b1, 1'b1, 6'h07, 8'h5C);
    drive(1'b1, 1'b0, 6'h07, 8'h00);
    en = 1'b0;
    #5 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (ready !== 1'b1 || rvalid !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL midread_rst got ready=%b rvalid=%b dout=%h want 1/0/00", ready, rvalid, dout); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 6'($urandom), 8'($urandom)); seen += int'(rvalid);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midread_no_rvalid got %0d pulses want 0", seen); end
    drive(1'b1, 1'b0, 6'h07, 8'h00);
    drive(1'b0, 1'b0, 6'h00, 8'h00);
    checks++; if (rvalid !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL midread_mem_clear got rvalid=%b dout=%h want 1/00", rvalid, dout); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 6'($urandom), 8'($urandom));
      if (i == 254) begin
        checks++; if (wr_cnt !== 8'd255) begin errors++; $display("FAIL wr_sat_reach got %0d want 255", wr_cnt); end
      end
    end
    checks++; if (wr_cnt !== 8'd255) begin errors++; $display("FAIL wr_sat_hold got %0d want 255", wr_cnt); end
    for (int i = 0; i < 260 * 3; i++) drive(1'b1, 1'b0, 6'($urandom), 8'($urandom));
    checks++; if (rd_cnt !== 8'd255 || wr_cnt !== 8'd255) begin errors++; $display("FAIL rd_sat_hold got %0d/%0d want 255/255", rd_cnt, wr_cnt); end
  endtask

  task automatic test_random();
    logic e, w;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      w = e ? 1'($urandom) : 1'bx;
      // narrow address range so reads frequently hit freshly written words
      drive(e, w, 6'($urandom_range(0, 7)), 8'($urandom));
      checks++;
      if (ready !== (busy == 0) || wack !== m_wack || rvalid !== m_rvalid || dout !== m_dout ||
          wr_cnt !== 8'(m_wcnt) || rd_cnt !== 8'(m_rcnt)) begin
        errors++;
        $display("FAIL rand cycle %0d got r=%b wa=%b rv=%b d=%h wc=%0d rc=%0d want r=%b wa=%b rv=%b d=%h wc=%0d rc=%0d",
                 i, ready, wack, rvalid, dout, wr_cnt, rd_cnt, busy == 0, m_wack, m_rvalid, m_dout, m_wcnt, m_rcnt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_then_read();
    test_back_to_back();
    test_continuous_read();
    test_reset_mid_read();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
